aliens_motion_ctrl: RTL and testbench
=====================================

# aliens_motion_ctrl

Alien formation step sequencer. It generates the 2-bit `motion` command consumed by the aliens-motion/collision block, and closes the loop on that block's `canLeft`, `canRight`, `killingAlien`, `victory` and `defeat` flags. It paces the formation with a reloadable step timer, sweeps it horizontally, and drops it one row whenever the current heading is blocked. It also shortens the step period on every kill and halts permanently on end of game.

## Interface
Parameters:
- `STEP_PERIOD`, 2_500_000: initial clock cycles between steps. Must be ≥ 4 so consumer flags settle between steps.
- `MIN_PERIOD`, 250_000: floor for the step period. Must satisfy 4 ≤ `MIN_PERIOD` ≤ `STEP_PERIOD`.
- `PERIOD_DEC`, 70_000: period reduction per kill (used only with speed-up compiled in).
- `CNT_W`, 24: width of the timer and period registers.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  asynchronous, active-high. Clears all state immediately.
- `enable`  in  1  game running. Low freezes the timer and forces `motion` = 00.
- `canLeft`  in  1  from consumer: leftmost live column may step left.
- `canRight`  in  1  from consumer: rightmost live column may step right.
- `killingAlien`  in  1  from consumer: one-cycle pulse per kill.
- `victory`  in  1  from consumer: all aliens dead.
- `defeat`  in  1  from consumer: formation reached the bottom limit.
- `motion`  out  2  step command. 00 idle, 01 right (x+), 10 left (x−), 11 down (y+).
- `dirRight`  out  1  current horizontal heading. 1 = right.
- `halted`  out  1  sticky end-of-game flag.
- `downCount`  out  8  number of down steps issued, saturating at 255.
- `period`  out  `CNT_W`  current step period, for debug and HUD.

## Operation
- FSM states: `RUN_R`, `RUN_L`, `HALT`. Reset state is `RUN_R`.
- Step timer:
  - `cnt` loads `period`−1 on reset and on each step.
  - It decrements while `enable` is high and the state is not `HALT`.
  - A step fires in the cycle where `cnt` = 0 and `enable` is high.
- On a step in `RUN_R`:
  - `canRight` = 1: `motion` = 01 and the state stays `RUN_R`.
  - `canRight` = 0: `motion` = 11, the state becomes `RUN_L`, and `downCount` increments.
- On a step in `RUN_L`: mirror image, using `canLeft` and `motion` = 10, switching to `RUN_R`.
- If both flags are low, each step issues a down move and flips the heading. No other recovery is performed.
- Flags are sampled in the step cycle only. Outside step cycles `motion` = 00.
- `victory` or `defeat` high in any cycle:
  - The state becomes `HALT` on the next edge and `halted` goes to 1.
  - This takes priority over a coincident step: that step's `motion` is forced to 00.
  - `HALT` persists until `reset`.
- `enable` low: `cnt` holds its value and `motion` = 00. Counting resumes from the held value when `enable` returns high.
- `dirRight` = 1 in `RUN_R`. In `HALT` it holds its last value.
- Arithmetic:
  - `period` update is unsigned and saturating: `period` = max(`period` − `PERIOD_DEC`, `MIN_PERIOD`), computed without underflow.
  - `downCount` saturates at 255.

## Timing
- Reset values: `motion` = 00, `dirRight` = 1, `halted` = 0, `downCount` = 0, `period` = `STEP_PERIOD`, `cnt` = `STEP_PERIOD`−1.
- Outputs are registered. `motion` is a single-cycle pulse in the cycle after `cnt` reaches 0.
- With continuous enable, the first step pulse appears `STEP_PERIOD` cycles after reset deasserts. Subsequent steps are spaced `period` cycles apart.
- A kill changes `period` one cycle after the `killingAlien` pulse. The new value applies at the next reload; the count already in progress is not shortened.
- `halted` rises one cycle after `victory`/`defeat`. No `motion` pulse is emitted from that edge onward.
- An asynchronous reset mid-operation returns every register to its reset value within the same cycle. The first step after release again takes `STEP_PERIOD` cycles.

## Configuration
- Macro: `ALIENS_SPEEDUP_EN`.
- Defined: each `killingAlien` pulse reduces `period` by `PERIOD_DEC`, floored at `MIN_PERIOD`.
- Undefined: `period` is constant at `STEP_PERIOD`, `killingAlien` is ignored, and the `period` output is tied to `STEP_PERIOD`.

## Structure
- Shared package `aliens_pkg` holds:
  - motion encodings `MOTION_IDLE`/`MOTION_RIGHT`/`MOTION_LEFT`/`MOTION_DOWN` (00/01/10/11), shared with the consumer block;
  - the FSM state type;
  - the default period constants.
- Sub-module `step_timer`: reloadable down-counter with `enable`, `reload`, `loadValue`, and a `tick` output. The top level owns the FSM, the period register and `downCount`.

## Test plan
- Scenario 1, basic stepping: `STEP_PERIOD` = 8, `enable` = 1, `canRight` = 1 → `motion` = 01 pulses at cycles 8, 16, 24 after reset release, 00 elsewhere.
- Scenario 2, edge reversal: `canRight` = 0 at step time in `RUN_R` → `motion` = 11, `dirRight` 1→0, `downCount` = 1. The next step with `canLeft` = 1 gives `motion` = 10.
- Scenario 3, speed-up (macro defined): `STEP_PERIOD` = 100, `PERIOD_DEC` = 30, `MIN_PERIOD` = 20, four kill pulses → `period` reads 70, 40, 20, 20. Step spacing becomes 20 after the reload that follows the third kill.
- Scenario 4, end of game: `defeat` is asserted in the same cycle `cnt` = 0 → no `motion` pulse, `halted` = 1 next cycle, and no further pulses for 1000 cycles.
- Scenario 5, enable and reset: `enable` low for 50 cycles mid-count → the step is delayed by exactly 50 cycles. `reset` pulsed mid-count → outputs return to reset values, and the next step comes `STEP_PERIOD` cycles after release.

Source files
------------

// File: rtl/aliens_pkg.sv
// Shared definitions for the alien formation sequencer and its motion/collision consumer.
package aliens_pkg;

    typedef enum logic [1:0] {
        MOTION_IDLE  = 2'b00,
        MOTION_RIGHT = 2'b01,
        MOTION_LEFT  = 2'b10,
        MOTION_DOWN  = 2'b11
    } motion_t;

    typedef enum logic [1:0] {
        RUN_R = 2'b00,
        RUN_L = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam int DEFAULT_STEP_PERIOD = 2_500_000;
    localparam int DEFAULT_MIN_PERIOD  = 250_000;
    localparam int DEFAULT_PERIOD_DEC  = 70_000;
    localparam int DEFAULT_CNT_W       = 24;

endpackage

// File: rtl/aliens_motion_if.sv
// Handshake between the formation sequencer (master) and the motion/collision block (slave).
interface aliens_motion_if #(parameter int CNT_W = 24);

    logic             enable;
    logic             canLeft;
    logic             canRight;
    logic             killingAlien;
    logic             victory;
    logic             defeat;
    logic [1:0]       motion;
    logic             dirRight;
    logic             halted;
    logic [7:0]       downCount;
    logic [CNT_W-1:0] period;

    modport master (
        input  enable, canLeft, canRight, killingAlien, victory, defeat,
        output motion, dirRight, halted, downCount, period
    );

    modport slave (
        output enable, canLeft, canRight, killingAlien, victory, defeat,
        input  motion, dirRight, halted, downCount, period
    );

endinterface

// File: rtl/aliens_motion_ctrl_step_timer.sv
// Reloadable down-counter pacing the formation; tick marks the terminal count while enabled.
module step_timer #(
    parameter int               CNT_W       = 24,
    parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             reload,
    input  logic [CNT_W-1:0] loadValue,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= RESET_VALUE;
        end else if (reload) begin
            cnt <= loadValue;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/aliens_motion_ctrl.sv
// Alien formation step sequencer: sweeps, drops on blocked heading, halts on end of game.
// Define ALIENS_SPEEDUP_EN to shorten the step period on every kill.
module aliens_motion_ctrl
    import aliens_pkg::*;
#(
    parameter int STEP_PERIOD = DEFAULT_STEP_PERIOD,
    parameter int MIN_PERIOD  = DEFAULT_MIN_PERIOD,
    parameter int PERIOD_DEC  = DEFAULT_PERIOD_DEC,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    aliens_motion_if.master bus
);

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] periodReg;
    logic [CNT_W-1:0] reloadValue;
    logic             tick;
    logic             timerEn;
    logic             endGame;
    motion_t          motionNext;
    logic             downStep;
    motion_t          motionReg;
    logic             dirRightReg;
    logic [7:0]       downCountReg;

    assign endGame     = bus.victory | bus.defeat;
    assign timerEn     = bus.enable && (state != HALT);
    assign reloadValue = periodReg - CNT_W'(1);

    step_timer #(
        .CNT_W       (CNT_W),
        .RESET_VALUE (CNT_W'(STEP_PERIOD - 1))
    ) uStepTimer (
        .clk       (clk),
        .reset     (reset),
        .enable    (timerEn),
        .reload    (tick),
        .loadValue (reloadValue),
        .tick      (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN_R;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (state != HALT) begin
            if (endGame) begin
                nextState = HALT;
            end else if (tick) begin
                case (state)
                    RUN_R:   if (!bus.canRight) nextState = RUN_L;
                    RUN_L:   if (!bus.canLeft)  nextState = RUN_R;
                    default: nextState = state;
                endcase
            end
        end
    end

    // End of game wins over a coincident step: that step is swallowed.
    always_comb begin
        motionNext = MOTION_IDLE;
        downStep   = 1'b0;
        if (tick && !endGame) begin
            case (state)
                RUN_R: begin
                    if (bus.canRight) begin
                        motionNext = MOTION_RIGHT;
                    end else begin
                        motionNext = MOTION_DOWN;
                        downStep   = 1'b1;
                    end
                end
                RUN_L: begin
                    if (bus.canLeft) begin
                        motionNext = MOTION_LEFT;
                    end else begin
                        motionNext = MOTION_DOWN;
                        downStep   = 1'b1;
                    end
                end
                default: motionNext = MOTION_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            motionReg    <= MOTION_IDLE;
            dirRightReg  <= 1'b1;
            downCountReg <= 8'd0;
        end else begin
            motionReg <= motionNext;
            if (nextState == RUN_R) begin
                dirRightReg <= 1'b1;
            end else if (nextState == RUN_L) begin
                dirRightReg <= 1'b0;
            end
            if (downStep && (downCountReg != 8'hFF)) begin
                downCountReg <= downCountReg + 8'd1;
            end
        end
    end

`ifdef ALIENS_SPEEDUP_EN
    // Compare one bit wider so the floor test can never wrap.
    localparam logic [CNT_W:0] FLOOR_PLUS_DEC = (CNT_W+1)'(MIN_PERIOD) + (CNT_W+1)'(PERIOD_DEC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            periodReg <= CNT_W'(STEP_PERIOD);
        end else if (bus.killingAlien && (state != HALT)) begin
            if ({1'b0, periodReg} >= FLOOR_PLUS_DEC) begin
                periodReg <= periodReg - CNT_W'(PERIOD_DEC);
            end else begin
                periodReg <= CNT_W'(MIN_PERIOD);
            end
        end
    end
`else
    assign periodReg = CNT_W'(STEP_PERIOD);
`endif

    assign bus.motion    = motionReg;
    assign bus.dirRight  = dirRightReg;
    assign bus.halted    = (state == HALT);
    assign bus.downCount = downCountReg;
    assign bus.period    = periodReg;

endmodule

// File: tb/tb_aliens_motion_ctrl.sv
// Directed scoreboard bench for aliens_motion_ctrl (default build and ALIENS_SPEEDUP_EN build).
module tb_aliens_motion_ctrl;
    import aliens_pkg::*;

    localparam int SP   = 8;
    localparam int MINP = 4;
    localparam int DEC  = 3;
    localparam int CW   = 16;

    typedef struct {
        int         cyc;
        logic [1:0] mot;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int   cyc        = 0;
    int   checks     = 0;
    int   errors     = 0;
    int   pulsesSeen = 0;
    int   stepAt     = 0;
    int   curPeriod  = SP;
    int   base       = 0;
    exp_t expQ[$];
    exp_t monE;

    aliens_motion_if #(.CNT_W(CW)) bus();

    aliens_motion_ctrl #(
        .STEP_PERIOD (SP),
        .MIN_PERIOD  (MINP),
        .PERIOD_DEC  (DEC),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset && bus.motion !== 2'b00) begin
            pulsesSeen++;
            checks++;
            assert (expQ.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse: observed motion=%b at cycle %0d, expected no pulse", bus.motion, cyc);
            end
            if (expQ.size() != 0) begin
                monE = expQ.pop_front();
                checks++;
                assert (bus.motion === monE.mot && cyc === monE.cyc) else begin
                    errors++;
                    $error("FAIL step_pulse: observed motion=%b cycle=%0d, expected motion=%b cycle=%0d",
                           bus.motion, cyc, monE.mot, monE.cyc);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic waitCyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) begin
            errors++;
            $error("FAIL wait_timeout: observed cycle %0d, expected cycle %0d", cyc, n);
        end
    endtask

    task automatic pushStep(input logic [1:0] m);
        exp_t e;
        e.cyc = stepAt;
        e.mot = m;
        expQ.push_back(e);
    endtask

    task automatic waitStep();
        waitCyc(stepAt);
        stepAt += curPeriod;
    endtask

    task automatic kill();
        bus.killingAlien = 1'b1;
        @(negedge clk);
        bus.killingAlien = 1'b0;
`ifdef ALIENS_SPEEDUP_EN
        curPeriod = (curPeriod - DEC < MINP) ? MINP : curPeriod - DEC;
`endif
        chk("period_after_kill", 32'(bus.period), 32'(curPeriod));
    endtask

    initial begin
        bus.enable       = 1'b1;
        bus.canRight     = 1'b1;
        bus.canLeft      = 1'b1;
        bus.killingAlien = 1'b0;
        bus.victory      = 1'b0;
        bus.defeat       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_motion",    32'(bus.motion),    32'd0);
        chk("rst_dirRight",  32'(bus.dirRight),  32'd1);
        chk("rst_halted",    32'(bus.halted),    32'd0);
        chk("rst_downCount", 32'(bus.downCount), 32'd0);
        chk("rst_period",    32'(bus.period),    32'(SP));
        reset     = 1'b0;
        stepAt    = SP;
        curPeriod = SP;

        // basic stepping right
        for (int i = 0; i < 3; i++) begin
            pushStep(MOTION_RIGHT);
            waitStep();
        end

        // reversal at the right edge, then left, then left edge, then both blocked
        bus.canRight = 1'b0;
        pushStep(MOTION_DOWN);
        waitStep();
        chk("rev_dirRight", 32'(bus.dirRight), 32'd0);
        chk("rev_downCount", 32'(bus.downCount), 32'd1);
        pushStep(MOTION_LEFT);
        waitStep();
        chk("left_dirRight", 32'(bus.dirRight), 32'd0);
        bus.canLeft = 1'b0;
        pushStep(MOTION_DOWN);
        waitStep();
        chk("ledge_dirRight", 32'(bus.dirRight), 32'd1);
        chk("ledge_downCount", 32'(bus.downCount), 32'd2);
        pushStep(MOTION_DOWN);
        waitStep();
        chk("both_dirRight", 32'(bus.dirRight), 32'd0);
        chk("both_downCount", 32'(bus.downCount), 32'd3);
        bus.canRight = 1'b1;
        bus.canLeft  = 1'b1;

        // kills: period shrinks to the floor, new value applies at the next reload
        waitCyc(cyc + 2);
        kill();
        pushStep(MOTION_LEFT);
        waitStep();
        waitCyc(cyc + 2);
        kill();
        pushStep(MOTION_LEFT);
        waitStep();
        kill();
        kill();
        pushStep(MOTION_LEFT);
        waitStep();
        pushStep(MOTION_LEFT);
        waitStep();

        // defeat in the terminal-count cycle swallows the step and halts for good
        waitCyc(stepAt - 1);
        bus.defeat = 1'b1;
        base = pulsesSeen;
        @(negedge clk);
        bus.defeat = 1'b0;
        chk("halt_rise", 32'(bus.halted), 32'd1);
        chk("halt_motion", 32'(bus.motion), 32'd0);
        repeat (1000) @(negedge clk);
        chk("halt_no_pulses", 32'(pulsesSeen), 32'(base));
        chk("halt_sticky", 32'(bus.halted), 32'd1);
        chk("halt_dirRight", 32'(bus.dirRight), 32'd0);

        // asynchronous reset out of HALT
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_halted",    32'(bus.halted),    32'd0);
        chk("arst_dirRight",  32'(bus.dirRight),  32'd1);
        chk("arst_downCount", 32'(bus.downCount), 32'd0);
        chk("arst_period",    32'(bus.period),    32'(SP));
        @(negedge clk);
        reset     = 1'b0;
        stepAt    = SP;
        curPeriod = SP;
        pushStep(MOTION_RIGHT);
        waitStep();

        // enable low for 50 cycles mid-count delays the step by 50
        waitCyc(cyc + 2);
        bus.enable = 1'b0;
        repeat (50) @(negedge clk);
        chk("frozen_motion", 32'(bus.motion), 32'd0);
        bus.enable = 1'b1;
        stepAt += 50;
        pushStep(MOTION_RIGHT);
        waitStep();

        // reset mid-count restarts the full first interval
        waitCyc(cyc + 3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_motion", 32'(bus.motion), 32'd0);
        chk("mid_rst_period", 32'(bus.period), 32'(SP));
        @(negedge clk);
        reset     = 1'b0;
        stepAt    = SP;
        curPeriod = SP;
        pushStep(MOTION_RIGHT);
        waitStep();

        // downCount saturation
        bus.canRight = 1'b0;
        bus.canLeft  = 1'b0;
        for (int i = 0; i < 257; i++) begin
            pushStep(MOTION_DOWN);
            waitStep();
        end
        chk("downCount_sat", 32'(bus.downCount), 32'd255);

        @(negedge clk);
        chk("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
